// File: rtl/tl45_wb_arbiter_pkg.sv
// ============================================================================
// Module   : tl45_wb_pkg
// Purpose  : Shared Wishbone types and default bus widths for TL45 bus
//            blocks (arbiter state encoding, word address / data widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tl45_wb_pkg;

  // Default widths reused by every TL45 Wishbone block.
  localparam int TL45_WB_ADDR_W = 30;
  localparam int TL45_WB_DATA_W = 32;

  // Arbiter ownership state. ABORT is only reachable when the ack timeout
  // is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/tl45_wb_arbiter_if.sv
// ============================================================================
// Module   : tl45_wb_arbiter_if
// Purpose  : Signal bundle for the N-master to 1-slave Wishbone arbiter.
//            Master-side ports are packed (master k occupies slice k).
//            modport slave  : the arbiter's view (it is the target of the
//                             master requests and sources the slave bus).
//            modport master : the surrounding system's view (masters plus
//                             the shared memory device).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tl45_wb_arbiter_if
  import tl45_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = TL45_WB_ADDR_W,
  parameter int DATA_W      = TL45_WB_DATA_W,
  parameter int SEL_W       = DATA_W / 8
);

  // Master side
  logic [NUM_MASTERS-1:0]        i_m_cyc;
  logic [NUM_MASTERS-1:0]        i_m_stb;
  logic [NUM_MASTERS-1:0]        i_m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] i_m_data;
  logic [NUM_MASTERS*SEL_W-1:0]  i_m_sel;
  logic [NUM_MASTERS-1:0]        o_m_ack;
  logic [NUM_MASTERS-1:0]        o_m_err;
  logic [NUM_MASTERS-1:0]        o_m_stall;
  logic [DATA_W-1:0]             o_m_data;

  // Slave side
  logic                          o_s_cyc;
  logic                          o_s_stb;
  logic                          o_s_we;
  logic [ADDR_W-1:0]             o_s_addr;
  logic [DATA_W-1:0]             o_s_data;
  logic [SEL_W-1:0]              o_s_sel;
  logic                          i_s_ack;
  logic                          i_s_stall;
  logic                          i_s_err;
  logic [DATA_W-1:0]             i_s_data;

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
    output o_m_ack, o_m_err, o_m_stall, o_m_data,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    input  i_s_ack, i_s_stall, i_s_err, i_s_data
  );

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
    input  o_m_ack, o_m_err, o_m_stall, o_m_data,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    output i_s_ack, i_s_stall, i_s_err, i_s_data
  );

endinterface

`default_nettype wire

// File: rtl/tl45_wb_arbiter_rr.sv
// ============================================================================
// Module   : tl45_rr_arbiter
// Purpose  : Combinational round-robin picker. Searches the request vector
//            starting one past the previous grant, wrapping, and returns the
//            first requester found.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl45_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  localparam int c_idx_w    = $clog2(NUM_MASTERS)
) (
  input  wire logic [NUM_MASTERS-1:0] i_req,
  input  wire logic [c_idx_w-1:0]     i_last_grant,
  output logic      [c_idx_w-1:0]     o_grant,
  output logic                        o_grant_valid
);

  // First requester after i_last_grant wins; i_last_grant itself is tried last.
  always_comb begin
    int w_idx;
    o_grant       = '0;
    o_grant_valid = 1'b0;
    w_idx         = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = (int'(i_last_grant) + i) % NUM_MASTERS;
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant       = c_idx_w'(w_idx);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl45_wb_arbiter.sv
// ============================================================================
// Module   : tl45_wb_arbiter
// Purpose  : N-master to 1-slave pipelined Wishbone arbiter. Round-robin
//            grant, ownership held for a whole CYC, outstanding-transfer
//            tracking so ACK/ERR only reach the owning master.
//            Optional ack timeout: define TL45_WBARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl45_wb_arbiter
  import tl45_wb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = TL45_WB_ADDR_W,
  parameter int DATA_W          = TL45_WB_DATA_W,
  parameter int SEL_W           = DATA_W / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input wire logic          i_clk,
  input wire logic          i_reset_n,
  tl45_wb_arbiter_if.slave  bus
);

  localparam int                 c_idx_w     = $clog2(NUM_MASTERS);
  localparam int                 c_cnt_w     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_max_out   = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(NUM_MASTERS - 1);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_MASTERS < 2) begin : g_chk_masters
    $error("tl45_wb_arbiter: NUM_MASTERS must be >= 2");
  end
  if ((DATA_W % 8) != 0) begin : g_chk_data_w
    $error("tl45_wb_arbiter: DATA_W must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("tl45_wb_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_t         r_state,       w_state_nxt;
  logic [c_idx_w-1:0] r_owner,       w_owner_nxt;
  logic [c_idx_w-1:0] r_last_grant,  w_last_grant_nxt;
  logic [c_cnt_w-1:0] r_outstanding, w_outstanding_nxt;

  logic [c_idx_w-1:0] w_grant;
  logic               w_grant_valid;
  logic               w_busy;
  logic               w_owner_cyc;
  logic               w_owner_stb;
  logic               w_full;
  logic               w_has_out;
  logic               w_s_stb;
  logic               w_accept;
  logic               w_retire;
  logic               w_timeout;

  tl45_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr (
    .i_req         (bus.i_m_cyc),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  assign w_busy      = (r_state == BUSY);
  assign w_owner_cyc = bus.i_m_cyc[r_owner];
  assign w_owner_stb = bus.i_m_stb[r_owner];
  assign w_full      = (r_outstanding == c_max_out);
  assign w_has_out   = (r_outstanding != '0);
  // No new request is issued on the cycle a timeout fires: the counter is
  // being cleared and the owner is about to be locked out.
  assign w_s_stb     = w_busy & w_owner_stb & ~w_full & ~w_timeout;
  assign w_accept    = w_s_stb & ~bus.i_s_stall;
  assign w_retire    = (bus.i_s_ack | bus.i_s_err) & w_has_out;

`ifdef TL45_WBARB_TIMEOUT_EN
  localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES);

  logic [c_tmr_w-1:0] r_timer;

  // Ack watchdog: runs only while the owner is waiting on a response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_timer <= '0;
    end else if (!w_busy || !w_has_out || bus.i_s_ack || bus.i_s_err) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = w_busy & w_has_out & ~bus.i_s_ack & ~bus.i_s_err &
                     (r_timer == c_tmr_w'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State, ownership and outstanding-count registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last_grant  <= c_last_init;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Next-state logic: grant from IDLE, release/abort from BUSY, and the
  // outstanding counter (a simultaneous accept and retire cancel out).
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_grant_nxt  = r_last_grant;
    w_outstanding_nxt = r_outstanding;
    case (r_state)
      IDLE: begin
        w_outstanding_nxt = '0;
        if (w_grant_valid) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_grant;
        end
      end
      BUSY: begin
        if (!w_owner_cyc) begin
          // Release or abort: anything still in flight is forgotten.
          w_state_nxt       = IDLE;
          w_last_grant_nxt  = r_owner;
          w_outstanding_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt       = ABORT;
          w_outstanding_nxt = '0;
        end else if (w_accept && !w_retire) begin
          w_outstanding_nxt = r_outstanding + 1'b1;
        end else if (!w_accept && w_retire) begin
          w_outstanding_nxt = r_outstanding - 1'b1;
        end
      end
      ABORT: begin
        if (!w_owner_cyc) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = r_owner;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bus muxing and response routing; everything idles to zero / stalled
  // unless a master owns the bus.
  always_comb begin
    bus.o_s_cyc   = 1'b0;
    bus.o_s_stb   = 1'b0;
    bus.o_s_we    = 1'b0;
    bus.o_s_addr  = '0;
    bus.o_s_data  = '0;
    bus.o_s_sel   = '0;
    bus.o_m_ack   = '0;
    bus.o_m_err   = '0;
    bus.o_m_stall = '1;
    if (w_busy) begin
      bus.o_s_cyc            = w_owner_cyc;
      bus.o_s_stb            = w_s_stb;
      bus.o_s_we             = bus.i_m_we[r_owner];
      bus.o_s_addr           = bus.i_m_addr[int'(r_owner)*ADDR_W +: ADDR_W];
      bus.o_s_data           = bus.i_m_data[int'(r_owner)*DATA_W +: DATA_W];
      bus.o_s_sel            = bus.i_m_sel[int'(r_owner)*SEL_W +: SEL_W];
      bus.o_m_stall[r_owner] = bus.i_s_stall | w_full | w_timeout;
      bus.o_m_ack[r_owner]   = bus.i_s_ack & w_has_out;
      bus.o_m_err[r_owner]   = (bus.i_s_err & w_has_out) | w_timeout;
    end
  end

  assign bus.o_m_data = bus.i_s_data;

endmodule

`default_nettype wire

// File: tb/tb_tl45_wb_arbiter.sv
// ============================================================================
// Module   : tb_tl45_wb_arbiter
// Purpose  : Directed self-checking bench for tl45_wb_arbiter (2 masters,
//            MAX_OUTSTANDING=2, TIMEOUT_CYCLES=16). Responses expected at the
//            masters are queued when the slave stimulus is driven and popped
//            by a monitor whenever an ACK/ERR appears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl45_wb_arbiter;
  import tl45_wb_pkg::*;

  localparam int NM   = 2;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int MAXO = 2;
  localparam int TMO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl45_wb_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

  tl45_wb_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int m1_acks     = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] data;
    logic        chk_data;
  } resp_t;
  resp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [1:0] ack, input logic [1:0] err,
                      input logic [31:0] d, input logic cd);
    resp_t e;
    e.ack = ack; e.err = err; e.data = d; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.i_m_cyc   = '0;
    bus.i_m_stb   = '0;
    bus.i_m_we    = '0;
    bus.i_m_addr  = '0;
    bus.i_m_data  = '0;
    bus.i_m_sel   = '0;
    bus.i_s_ack   = 1'b0;
    bus.i_s_stall = 1'b0;
    bus.i_s_err   = 1'b0;
    bus.i_s_data  = '0;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    bus.i_m_addr[k*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    settle();
    check("rst_s_cyc", bus.o_s_cyc, 0);
    check("rst_s_stb", bus.o_s_stb, 0);
    check("rst_m_ack", bus.o_m_ack, 0);
    check("rst_m_err", bus.o_m_err, 0);
    check("rst_m_stall", bus.o_m_stall, 2'b11);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Response monitor: every ACK/ERR seen by a master must match the queue head.
  always @(negedge clk) begin
    resp_t e;
    if (bus.o_m_ack != '0 || bus.o_m_err != '0) begin
      if (bus.o_m_ack[1]) m1_acks++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {60'd0, bus.o_m_ack, bus.o_m_err}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_ack", bus.o_m_ack, e.ack);
        check("resp_err", bus.o_m_err, e.err);
        if (e.chk_data) check("resp_data", bus.o_m_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, acks, out, k, ack_idx, m1_base, n;
    int acc_t[4];
    bit sst, sack, stalled_once, seen;

    // ---------------- reset ----------------
    do_reset();

    // ---------------- 1: single read by master 0 ----------------
    tick();
    bus.i_m_cyc = 2'b01; bus.i_m_stb = 2'b01; set_addr(0, 30'h10);
    settle();
    check("s1_grant_latency", bus.o_s_cyc, 0);
    tick(); settle();
    check("s1_s_cyc", bus.o_s_cyc, 1);
    check("s1_s_stb", bus.o_s_stb, 1);
    check("s1_s_addr", bus.o_s_addr, 30'h10);
    check("s1_stall", bus.o_m_stall, 2'b10);
    tick();
    bus.i_m_stb = 2'b00; bus.i_s_ack = 1'b1; bus.i_s_data = 32'hDEADBEEF;
    push(2'b01, 2'b00, 32'hDEADBEEF, 1'b1);
    settle();
    check("s1_ack", bus.o_m_ack, 2'b01);
    check("s1_data", bus.o_m_data, 32'hDEADBEEF);
    tick();
    bus.i_s_ack = 1'b0; bus.i_m_cyc = 2'b00;
    settle();
    check("s1_release", bus.o_s_cyc, 0);
    check("s1_no_ack", bus.o_m_ack, 2'b00);
    tick();

    // ---------------- 2: simultaneous requests, round robin ----------------
    do_reset();
    tick();
    bus.i_m_cyc = 2'b11;
    tick(); settle();
    check("s2_m0_owns", bus.o_m_stall, 2'b10);
    check("s2_s_cyc", bus.o_s_cyc, 1);
    tick(); settle();
    check("s2_m1_waits", bus.o_m_stall, 2'b10);
    tick();
    bus.i_m_cyc = 2'b10;
    settle();
    check("s2_release_cyc", bus.o_s_cyc, 0);
    tick(); settle();
    check("s2_idle_gap", bus.o_s_cyc, 0);
    check("s2_idle_stall", bus.o_m_stall, 2'b11);
    tick(); settle();
    check("s2_m1_granted", bus.o_m_stall, 2'b01);
    check("s2_m1_cyc", bus.o_s_cyc, 1);
    tick();
    bus.i_m_cyc = 2'b00;
    tick();
    bus.i_m_cyc = 2'b11;
    tick(); settle();
    check("s2_rr_back_to_m0", bus.o_m_stall, 2'b10);
    tick();
    bus.i_m_cyc = 2'b00;
    tick();

    // ---------------- 3: pipelined burst, stall, full, late acks ----------------
    bus.i_m_cyc = 2'b10; bus.i_m_stb = 2'b10; set_addr(1, 30'h200);
    tick();
    issued = 0; acks = 0; out = 0; k = 0; stalled_once = 0; m1_base = m1_acks;
    while (acks < 4 && k < 40) begin
      sst = (issued == 1) && !stalled_once;
      if (sst) stalled_once = 1;
      sack = 0; ack_idx = 0;
      for (int j = 0; j < issued; j++) begin
        if (acc_t[j] + 3 == k) begin sack = 1; ack_idx = j; end
      end
      bus.i_m_stb   = (issued < 4) ? 2'b10 : 2'b00;
      set_addr(1, AW'(32'h200 + issued));
      bus.i_s_stall = sst;
      bus.i_s_ack   = sack;
      bus.i_s_data  = 32'h1000_0000 + ack_idx;
      if (sack) push(2'b10, 2'b00, 32'h1000_0000 + ack_idx, 1'b1);
      settle();
      check("s3_stall", bus.o_m_stall, {sst || (out == MAXO), 1'b1});
      check("s3_s_stb", bus.o_s_stb, (issued < 4) && (out != MAXO));
      if (issued < 4 && out != MAXO && !sst) begin
        acc_t[issued] = k;
        issued++;
        out++;
      end
      if (sack) begin out--; acks++; end
      tick();
      k++;
    end
    check("s3_loop_budget", k < 40, 1);
    check("s3_acks_to_m1", m1_acks - m1_base, 4);
    bus.i_s_ack = 1'b0; bus.i_s_stall = 1'b0; bus.i_m_stb = 2'b10;
    settle();
    check("s3_drain_cnt0", bus.o_m_stall, 2'b01);
    tick(); settle();
    check("s3_drain_cnt1", bus.o_m_stall, 2'b01);
    tick(); settle();
    check("s3_drain_full", bus.o_m_stall, 2'b11);
    tick();
    bus.i_m_stb = 2'b00; bus.i_s_ack = 1'b1; bus.i_s_data = 32'h55;
    push(2'b10, 2'b00, 32'h55, 1'b1);
    tick();
    push(2'b10, 2'b00, 32'h55, 1'b1);
    tick();
    bus.i_s_ack = 1'b0; bus.i_m_cyc = 2'b00;
    tick();

    // ---------------- 4: abort with outstanding transfers ----------------
    bus.i_m_cyc = 2'b01; bus.i_m_stb = 2'b01; set_addr(0, 30'h40);
    tick();
    tick();
    tick();
    bus.i_m_stb = 2'b00; bus.i_m_cyc = 2'b00;
    settle();
    check("s4_abort_cyc", bus.o_s_cyc, 0);
    tick();
    bus.i_s_ack = 1'b1; bus.i_m_cyc = 2'b10;
    settle();
    check("s4_drop_idle", bus.o_m_ack, 2'b00);
    tick(); settle();
    check("s4_drop_busy", bus.o_m_ack, 2'b00);
    check("s4_m1_cyc", bus.o_s_cyc, 1);
    tick();
    bus.i_s_ack = 1'b0; bus.i_m_stb = 2'b10;
    settle();
    check("s4_cnt0", bus.o_m_stall, 2'b01);
    tick(); settle();
    check("s4_cnt1", bus.o_m_stall, 2'b01);
    tick(); settle();
    check("s4_full", bus.o_m_stall, 2'b11);
    tick();
    bus.i_m_stb = 2'b00; bus.i_s_ack = 1'b1; bus.i_s_data = 32'hA5A5A5A5;
    push(2'b10, 2'b00, 32'hA5A5A5A5, 1'b1);
    tick();
    push(2'b10, 2'b00, 32'hA5A5A5A5, 1'b1);
    tick();
    bus.i_s_ack = 1'b0; bus.i_m_cyc = 2'b00;
    tick();

    // ---------------- 5: error on a write ----------------
    bus.i_m_cyc = 2'b01; bus.i_m_stb = 2'b01; bus.i_m_we = 2'b01;
    set_addr(0, 30'h80);
    bus.i_m_data[0 +: DW] = 32'hCAFEF00D;
    bus.i_m_sel[0 +: SW]  = 4'hF;
    tick(); settle();
    check("s5_s_we", bus.o_s_we, 1);
    check("s5_s_data", bus.o_s_data, 32'hCAFEF00D);
    check("s5_s_sel", bus.o_s_sel, 4'hF);
    tick();
    bus.i_m_stb = 2'b00; bus.i_s_err = 1'b1;
    push(2'b00, 2'b01, 32'h0, 1'b0);
    settle();
    check("s5_err", bus.o_m_err, 2'b01);
    check("s5_no_ack", bus.o_m_ack, 2'b00);
    tick();
    bus.i_s_err = 1'b0;
    settle();
    check("s5_err_one_cycle", bus.o_m_err, 2'b00);
    check("s5_still_owned", bus.o_s_cyc, 1);
    tick(); settle();
    check("s5_still_owned2", bus.o_s_cyc, 1);
    bus.i_m_cyc = 2'b00; bus.i_m_we = 2'b00;
    tick();
    tick();

`ifdef TL45_WBARB_TIMEOUT_EN
    // ---------------- 6: ack timeout ----------------
    bus.i_m_cyc = 2'b10; bus.i_m_stb = 2'b10; set_addr(1, 30'h300);
    tick(); settle();
    check("t_accept", bus.o_m_stall, 2'b01);
    push(2'b00, 2'b10, 32'h0, 1'b0);
    tick();
    bus.i_m_stb = 2'b00;
    n = 1; seen = 0;
    while (!seen && n < 40) begin
      settle();
      if (bus.o_m_err[1]) seen = 1;
      else begin tick(); n++; end
    end
    check("t_err_cycle", n, TMO);
    check("t_err_cyc_held", bus.o_s_cyc, 1);
    tick();
    bus.i_s_ack = 1'b1;
    settle();
    check("t_abort_cyc", bus.o_s_cyc, 0);
    check("t_abort_stall", bus.o_m_stall, 2'b11);
    check("t_abort_no_ack", bus.o_m_ack, 2'b00);
    check("t_abort_no_err", bus.o_m_err, 2'b00);
    tick();
    bus.i_s_ack = 1'b0; bus.i_m_cyc = 2'b00;
    tick();
    bus.i_m_cyc = 2'b01;
    tick(); settle();
    check("t_regrant", bus.o_s_cyc, 1);
    bus.i_m_cyc = 2'b00;
    tick();
    tick();
`endif

    // ---------------- 7: reset mid-burst ----------------
    bus.i_m_cyc = 2'b01; bus.i_m_stb = 2'b01; set_addr(0, 30'h99);
    tick();
    tick();
    bus.i_s_ack = 1'b1;
    rst_n = 1'b0;
    settle();
    check("r_s_cyc", bus.o_s_cyc, 0);
    check("r_s_stb", bus.o_s_stb, 0);
    check("r_stall", bus.o_m_stall, 2'b11);
    check("r_ack", bus.o_m_ack, 2'b00);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
